dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel arbiter and bus-hold sequencer for the 8237A-style DMA controller. It qualifies the per-channel DREQ lines against the mask register and controller-disable bit, and requests the bus from the CPU via HRQ/HLDA. It resolves fixed or rotating priority, issues one-hot DACK to the winning channel and holds the grant until the transfer engine signals end of service.

## Interface
- NCH, 4, number of DMA channels (2..8); channel 0 is highest priority in fixed mode.
- CW, $clog2(NCH), width of the channel index output.

- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dreq  in  NCH  channel requests, active-high, level-sensitive.
- mask  in  NCH  mask register; 1 = channel ignored.
- ctrl_disable  in  1  command-register controller disable; 1 blocks new arbitration.
- rotating  in  1  priority mode: 0 = fixed, 1 = rotating.
- hlda  in  1  hold acknowledge from CPU.
- svc_done  in  1  one-cycle pulse from the transfer engine: current service finished (TC/EOP/demand drop).
- hrq  out  NCH-independent 1  hold request to CPU.
- dack  out  NCH  one-hot acknowledge, active-high.
- grant_ch  out  CW  index of the granted channel; valid while aen=1.
- aen  out  1  address enable; high while a channel is in service.
- busy  out  1  high in every state except IDLE.

## Operation
- valid = dreq & ~mask, gated to 0 when ctrl_disable=1. Evaluated combinationally every cycle.
- Rotation pointer `last` (CW bits) resets to NCH-1, so channel 0 is highest priority after reset.
- Fixed mode: lowest-index valid channel wins. Rotating mode: the search starts at (last+1) mod NCH and wraps. The first valid channel found wins.
- The mode input is sampled only at arbitration. A mode change mid-service applies at the next arbitration.
- FSM states: IDLE, HOLD_WAIT, SERVICE, RELEASE.
  - IDLE: any valid -> HOLD_WAIT, hrq=1.
  - HOLD_WAIT: hlda=1 and valid≠0 -> arbitrate, latch winner, -> SERVICE. hlda=1 and valid=0 (request withdrawn) -> RELEASE, hrq=0. hlda=0 -> stay.
  - SERVICE: dack[winner]=1, aen=1, grant_ch=winner. Mask and dreq changes are ignored. svc_done=1 -> last=winner, clear dack/aen, hrq=0, -> RELEASE. hlda=0 before svc_done (CPU preemption) -> abort, dack/aen cleared, last unchanged, hrq=0, -> RELEASE.
  - RELEASE: wait for hlda=0, then -> IDLE. hrq is never reasserted in RELEASE.
- svc_done outside SERVICE is ignored.
- svc_done and hlda falling in the same cycle count as a normal completion: last is updated.
- Reset, asynchronous, in any state: IDLE, hrq=0, dack=0, aen=0, grant_ch=0, busy=0, last=NCH-1. There is no partial completion.

## Timing
- All outputs are registered.
- Reset values: hrq=0, dack=0, grant_ch=0, aen=0, busy=0.
- First valid request seen at edge N: hrq=1 and busy=1 after edge N.
- hlda sampled 1 at edge M: dack, aen and grant_ch valid after edge M. One-cycle hold-to-grant latency.
- svc_done sampled at edge K: dack=0, aen=0 and hrq=0 after edge K.
- Minimum IDLE-to-IDLE round trip with hlda tracking hrq after 1 cycle: 5 cycles.
- hrq stays low for at least 1 cycle between grants (RELEASE->IDLE->HOLD_WAIT).
- dack is at most one-hot at all times. aen equals |dack.

## Test plan
- Fixed priority: rotating=0, dreq=4'b1010, hlda follows hrq after 1 cycle -> dack=4'b0010, grant_ch=1. svc_done -> next grant dack=4'b1000.
- Rotating: rotating=1, dreq=4'b1111 held, svc_done 3 cycles after each grant -> grant sequence 0,1,2,3,0, with hrq dropping between grants.
- Masking/disable: dreq=4'b0001, mask=4'b0001 -> hrq stays 0. Clear mask but set ctrl_disable=1 -> hrq stays 0. Clear ctrl_disable -> hrq=1 next cycle.
- Withdrawn request: dreq=4'b0100 raises hrq, then dreq=0 before hlda=1 -> no dack, hrq=0 the cycle after hlda, IDLE after hlda drops.
- Preemption: in SERVICE on ch2 with rotating=1, drop hlda -> dack=0 and hrq=0 next cycle, last unchanged. Re-request with all channels -> ch0 wins again.
- Reset mid-service: reset low during SERVICE -> outputs zero immediately, without waiting for a clock. After release, rotating arbitration with dreq=4'b1111 -> ch0 first.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter and bus-hold sequencer.
// Qualifies channel requests against the mask and controller-disable bit.
// Requests the bus through hrq/hlda, picks a winner by fixed or rotating
// priority, and holds a one-hot dack until the transfer engine reports svc_done.
module dma_priority_arbiter #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = $clog2(NCH)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [NCH-1:0] dreq,
   input  logic [NCH-1:0] mask,
   input  logic           ctrl_disable,
   input  logic           rotating,
   input  logic           hlda,
   input  logic           svc_done,
   output logic           hrq,
   output logic [NCH-1:0] dack,
   output logic [CW-1:0]  grant_ch,
   output logic           aen,
   output logic           busy
);

   typedef enum logic [1:0] {
      StIdle,
      StHoldWait,
      StService,
      StRelease
   } state_e;

   state_e          state_q;
   logic [CW-1:0]   last_q;
   logic [NCH-1:0]  valid;
   logic            win_found;
   logic [CW-1:0]   win_idx;
   int              cand;

   // Qualified requests; controller disable blocks every channel.
   always_comb begin
      valid = ctrl_disable ? '0 : (dreq & ~mask);
   end

   // Priority search: from channel 0 in fixed mode, from last+1 (wrapping) in rotating mode.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (rotating) begin
            cand = (int'(last_q) + 1 + i) % int'(NCH);
         end else begin
            cand = i;
         end
         if (!win_found && valid[CW'(cand)]) begin
            win_found = 1'b1;
            win_idx   = CW'(cand);
         end
      end
   end

   // Hold/grant sequencer with all outputs registered.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         last_q   <= CW'(NCH - 1);
         hrq      <= 1'b0;
         dack     <= '0;
         grant_ch <= '0;
         aen      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (|valid) begin
                  state_q <= StHoldWait;
                  hrq     <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            StHoldWait: begin
               if (hlda) begin
                  if (win_found) begin
                     state_q  <= StService;
                     dack     <= NCH'(1) << win_idx;
                     grant_ch <= win_idx;
                     aen      <= 1'b1;
                  end else begin
                     // Request withdrawn before the bus arrived: give it back.
                     state_q <= StRelease;
                     hrq     <= 1'b0;
                  end
               end
            end
            StService: begin
               // svc_done wins over a simultaneous hlda drop: counts as completion.
               if (svc_done) begin
                  last_q  <= grant_ch;
                  state_q <= StRelease;
                  dack    <= '0;
                  aen     <= 1'b0;
                  hrq     <= 1'b0;
               end else if (!hlda) begin
                  // CPU preempted the bus; rotation pointer is left untouched.
                  state_q <= StRelease;
                  dack    <= '0;
                  aen     <= 1'b0;
                  hrq     <= 1'b0;
               end
            end
            StRelease: begin
               if (!hlda) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               hrq     <= 1'b0;
               dack    <= '0;
               aen     <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized self-checking bench for dma_priority_arbiter against a
// transaction-level reference model of the hold/grant protocol.
module tb_dma_priority_arbiter;

   localparam int NCH = 4;
   localparam int CW  = $clog2(NCH);

   logic           clock;
   logic           reset;
   logic [NCH-1:0] dreq;
   logic [NCH-1:0] mask;
   logic           ctrl_disable;
   logic           rotating;
   logic           hlda;
   logic           svc_done;
   logic           hrq;
   logic [NCH-1:0] dack;
   logic [CW-1:0]  grant_ch;
   logic           aen;
   logic           busy;

   int n_vec;
   int n_err;

   // Reference model state: phase 0 idle, 1 awaiting bus, 2 serving, 3 giving bus back.
   int m_phase;
   int m_last;
   int m_win;
   int e_hrq;
   int e_dack;
   int e_aen;
   int e_busy;
   int grants [NCH];
   bit reset_done;

   dma_priority_arbiter #(
      .NCH (NCH),
      .CW  (CW)
   ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .dreq         (dreq),
      .mask         (mask),
      .ctrl_disable (ctrl_disable),
      .rotating     (rotating),
      .hlda         (hlda),
      .svc_done     (svc_done),
      .hrq          (hrq),
      .dack         (dack),
      .grant_ch     (grant_ch),
      .aen          (aen),
      .busy         (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner = valid channel closest after the last served one (rotating), or lowest index.
   function automatic int pick(input int v, input bit rot, input int last);
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = NCH;
      for (int ch = 0; ch < NCH; ch++) begin
         if (v[ch]) begin
            d = rot ? (ch - last - 1 + 2 * NCH) % NCH : ch;
            if (d < bestd) begin
               bestd = d;
               best  = ch;
            end
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_last  = NCH - 1;
      m_win   = 0;
      e_hrq   = 0;
      e_dack  = 0;
      e_aen   = 0;
      e_busy  = 0;
   endtask

   task automatic model_step();
      int v;
      v = ctrl_disable ? 0 : int'(dreq & ~mask);
      case (m_phase)
         0: if (v != 0) begin
            m_phase = 1;
            e_hrq   = 1;
         end
         1: if (hlda) begin
            if (v != 0) begin
               m_win   = pick(v, rotating, m_last);
               e_dack  = 1 << m_win;
               e_aen   = 1;
               m_phase = 2;
               grants[m_win]++;
            end else begin
               e_hrq   = 0;
               m_phase = 3;
            end
         end
         2: if (svc_done || !hlda) begin
            if (svc_done) m_last = m_win;
            e_dack  = 0;
            e_aen   = 0;
            e_hrq   = 0;
            m_phase = 3;
         end
         default: if (!hlda) m_phase = 0;
      endcase
      e_busy = (m_phase != 0) ? 1 : 0;
   endtask

   task automatic compare_outputs(input string pfx);
      check({pfx, "hrq"},  32'(hrq),  32'(e_hrq));
      check({pfx, "dack"}, 32'(dack), 32'(e_dack));
      check({pfx, "aen"},  32'(aen),  32'(e_aen));
      check({pfx, "busy"}, 32'(busy), 32'(e_busy));
      if (e_aen != 0) check({pfx, "grant_ch"}, 32'(grant_ch), 32'(m_win));
   endtask

   task automatic check_reset_zero(input string pfx);
      check({pfx, "hrq"},      32'(hrq),      32'd0);
      check({pfx, "dack"},     32'(dack),     32'd0);
      check({pfx, "aen"},      32'(aen),      32'd0);
      check({pfx, "busy"},     32'(busy),     32'd0);
      check({pfx, "grant_ch"}, 32'(grant_ch), 32'd0);
   endtask

   task automatic new_stimulus();
      int r;
      r = int'($urandom_range(0, 15));
      if (hrq) begin
         if (r < 12) hlda = 1'b1;
         if (r == 15) hlda = 1'b0;
      end else if (r < 10) begin
         hlda = 1'b0;
      end
      svc_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) dreq = NCH'($urandom);
      if ($urandom_range(0, 31) == 0) mask = NCH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) ctrl_disable = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) rotating = ~rotating;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      reset_done   = 1'b0;
      reset        = 1'b0;
      dreq         = '0;
      mask         = '0;
      ctrl_disable = 1'b0;
      rotating     = 1'b0;
      hlda         = 1'b0;
      svc_done     = 1'b0;
      for (int i = 0; i < NCH; i++) grants[i] = 0;
      model_reset();
      #1;
      check_reset_zero("por_");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      rotating = 1'b1;
      dreq = '1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clock);
         model_step();
         @(negedge clock);
         compare_outputs("");
         if (cyc > 1500 && !reset_done && m_phase == 2) begin
            reset_done = 1'b1;
            #2 reset = 1'b0;
            #1 check_reset_zero("async_rst_");
            model_reset();
            @(posedge clock);
            @(negedge clock);
            check_reset_zero("held_rst_");
            reset    = 1'b1;
            hlda     = 1'b0;
            svc_done = 1'b0;
            rotating = 1'b1;
            dreq     = '1;
            mask     = '0;
            ctrl_disable = 1'b0;
         end else begin
            new_stimulus();
         end
      end

      // Every channel must have been granted at least once under random traffic.
      for (int i = 0; i < NCH; i++) check($sformatf("coverage_ch%0d", i), 32'(grants[i] > 0), 32'd1);
      check("async_reset_exercised", 32'(reset_done), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
